time_diff_meter: RTL
====================

# time_diff_meter

Parametrised two-channel time-interval meter for the oscilloscope datapath. Measures the number of clk_100M cycles (10 ns each) from a selected edge on `sign0` to the same edge on `sign1`. Each result is converted to packed BCD by a sequential, one-bit-per-cycle double-dabble engine and announced with a one-cycle valid strobe. Adds selectable edge polarity, counter saturation with an overflow flag, a busy indication, and result hold between measurements.

## Interface
- `CNT_W`, 27: width of the interval counter and of `diff_out`.
- `BCD_DIGITS`, 9: number of BCD digits. Must satisfy 10^BCD_DIGITS > 2^CNT_W − 1; this is not checked at run time.
- `SYNC_STAGES`, 2: synchroniser depth on `sign0` and `sign1` (minimum 2).

Ports:
- `clk_100M` input 1: system clock, 100 MHz.
- `rst` input 1: asynchronous, active-low reset.
- `sign0` input 1: start channel, asynchronous.
- `sign1` input 1: stop channel, asynchronous.
- `edge_sel` input 1: 0 = rising edges, 1 = falling edges.
- `diff_out` output CNT_W: last measured interval, in cycles.
- `bcd_out` output 4*BCD_DIGITS: packed BCD of `diff_out`, least-significant digit in [3:0].
- `valid` output 1: one-cycle pulse when a new result is presented.
- `overflow` output 1: the last result saturated (no stop edge seen).
- `busy` output 1: high in COUNT, CONVERT and DONE.

## Operation
- **Input conditioning**
  - Each input passes through a SYNC_STAGES flop chain.
  - A `prev` register holds the previous synchronised value.
  - Edge strobe e0/e1 = (sync & ~prev) for rising, (~sync & prev) for falling.
  - `prev` resets to 1 for rising mode semantics, so a high level after reset gives no edge.
  - `prev` updates every cycle in every state.
- **`edge_sel` handling:** sampled into `mode_q` only in IDLE. It is held constant through COUNT.
- **IDLE**
  - e0 & ~e1: counter ← 1, go to COUNT.
  - e0 & e1 in the same cycle: capture 0, overflow_q ← 0, go to CONVERT.
  - e1 alone: ignored.
- **COUNT**
  - e1: capture counter, overflow_q ← 0, go to CONVERT.
  - Otherwise, if counter == 2^CNT_W−1: capture all-ones, overflow_q ← 1, go to CONVERT.
  - Otherwise: counter ← counter+1.
  - Further e0 strobes are ignored; the measurement does not restart.
- **CONVERT**
  - Shift register = {BCD field, captured value}.
  - Each cycle: every digit ≥ 5 gets +3, then shift left 1.
  - Exactly CNT_W cycles, tracked by an iteration counter.
  - All edges are ignored.
- **DONE** (1 cycle)
  - `diff_out` ← captured value, `bcd_out` ← BCD field, `overflow` ← overflow_q, `valid` = 1.
  - Return to IDLE.
- **Result hold:** outputs hold their values until the next DONE. A zero interval is a legal result and is reported like any other.
- **Arithmetic:** counter is CNT_W bits unsigned and saturates, never wraps. BCD digits never exceed 9.

## Timing
- **Reset values:** all outputs 0. State IDLE, counter 0, synchronisers 0, `prev` 1.
- **Reset mid-operation:** immediate return to IDLE. Any partial result is discarded, with no `valid` pulse.
- **Pin to strobe:** a pin edge produces e0/e1 SYNC_STAGES+1 cycles later.
- **Measured value:** e0 strobe in cycle t0 and e1 strobe in cycle t1 give `diff_out` = t1 − t0.
- **Stop to result:** `valid` rises CNT_W+1 cycles after the e1 strobe cycle (CNT_W CONVERT cycles plus DONE). `diff_out`/`bcd_out`/`overflow` change in the same cycle as `valid`.
- **Overflow timing:** without a stop edge, `valid` with `overflow`=1 appears 2^CNT_W−1 cycles after t0, plus CNT_W+1 cycles.
- **`busy`:** rises the cycle after the e0 strobe and falls the cycle after DONE.
- **Re-arm:** the earliest next e0 accepted is the cycle after DONE.

## Test plan
- **Basic rising:** defaults, rising mode; `sign0` rises, `sign1` rises 1234 cycles later → `diff_out`=1234, `bcd_out`=36'h000001234, `overflow`=0, `valid` pulses once, 28 cycles after the e1 strobe.
- **Simultaneous and stop-first:** `sign0` and `sign1` rise in the same cycle → `diff_out`=0, `bcd_out`=0, `valid` pulses. Separately, `sign1` rising alone in IDLE → no `busy`, no `valid`.
- **Falling mode, ignored edges:** `edge_sel`=1; falling edges 99999999 cycles apart, with extra `sign0` edges in between → `bcd_out`=36'h099999999, extra edges ignored.
- **Overflow:** CNT_W=8, BCD_DIGITS=3, `sign1` held low → `diff_out`=255, `bcd_out`=12'h255, `overflow`=1. A following 7-cycle interval gives `overflow`=0, `bcd_out`=12'h007.
- **Reset mid-convert:** `rst` low during CONVERT → all outputs 0, no `valid`. The next measurement of 50 cycles gives `bcd_out`=36'h000000050.
- **Glitch immunity:** `sign0` held high through reset release (rising mode) → no measurement starts until a genuine 0→1 transition.

Source files
------------

// File: rtl/time_diff_meter.sv
// == time_diff_meter: sign0->sign1 interval meter with serial double-dabble BCD output (rev 1.0) ==
`default_nettype none

module time_diff_meter #(
  parameter int CNT_W       = 27,
  parameter int BCD_DIGITS  = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_100M,
  input  logic                    rst,
  input  logic                    sign0,
  input  logic                    sign1,
  input  logic                    edge_sel,
  output logic [CNT_W-1:0]        diff_out,
  output logic [4*BCD_DIGITS-1:0] bcd_out,
  output logic                    valid,
  output logic                    overflow,
  output logic                    busy
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int SR_W  = BCD_W + CNT_W;
  localparam int IT_W  = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IT_W-1:0]  IT_LAST  = IT_W'(CNT_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync0, sync1;
  logic [SYNC_STAGES:0]   warm;
  logic                   prev0, prev1, mode_q;
  logic                   s0, s1, armed, e0, e1;
  logic [CNT_W-1:0]       counter, cap;
  logic                   ovf_q;
  logic [SR_W-1:0]        sr, dd_adj, dd_next;
  logic [IT_W-1:0]        iter;
  logic                   last_iter;

  assign s0    = sync0[SYNC_STAGES-1];
  assign s1    = sync1[SYNC_STAGES-1];
  // Strobes stay masked until both sync output and prev hold post-reset samples.
  assign armed = warm[SYNC_STAGES];
  assign e0    = armed & (mode_q ? (prev0 & ~s0) : (s0 & ~prev0));
  assign e1    = armed & (mode_q ? (prev1 & ~s1) : (s1 & ~prev1));

  assign last_iter = (iter == IT_LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      sync0  <= '0;
      sync1  <= '0;
      warm   <= '0;
      prev0  <= 1'b1;
      prev1  <= 1'b1;
      mode_q <= 1'b0;
    end else begin
      sync0 <= {sync0[SYNC_STAGES-2:0], sign0};
      sync1 <= {sync1[SYNC_STAGES-2:0], sign1};
      warm  <= {warm[SYNC_STAGES-1:0], 1'b1};
      prev0 <= s0;
      prev1 <= s1;
      if (state == IDLE) mode_q <= edge_sel;
    end
  end

  always_comb begin
    dd_adj = sr;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (sr[CNT_W+4*d +: 4] >= 4'd5) dd_adj[CNT_W+4*d +: 4] = sr[CNT_W+4*d +: 4] + 4'd3;
    end
    dd_next = {dd_adj[SR_W-2:0], 1'b0};
  end

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (e0) state_nxt = e1 ? CONVERT : COUNT;
      COUNT:   if (e1 || counter == CNT_MAX) state_nxt = CONVERT;
      CONVERT: if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      counter  <= '0;
      cap      <= '0;
      ovf_q    <= 1'b0;
      sr       <= '0;
      iter     <= '0;
      diff_out <= '0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (e0 && e1) begin
            cap   <= '0;
            ovf_q <= 1'b0;
            sr    <= '0;
            iter  <= '0;
          end else if (e0) begin
            counter <= CNT_W'(1);
          end
        end
        COUNT: begin
          if (e1) begin
            cap   <= counter;
            ovf_q <= 1'b0;
            sr    <= {{BCD_W{1'b0}}, counter};
            iter  <= '0;
          end else if (counter == CNT_MAX) begin
            cap   <= CNT_MAX;
            ovf_q <= 1'b1;
            sr    <= {{BCD_W{1'b0}}, CNT_MAX};
            iter  <= '0;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        CONVERT: begin
          sr   <= dd_next;
          iter <= iter + IT_W'(1);
          // Publish on the final shift so outputs change together with valid in DONE.
          if (last_iter) begin
            diff_out <= cap;
            bcd_out  <= dd_next[SR_W-1 -: BCD_W];
            overflow <= ovf_q;
            valid    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
